// File: rtl/cnn_pkg.sv
// Shared CNN types: drain FSM state encoding and checksum width.
package cnn_pkg;

  localparam int CHECKSUM_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
// Head is visible combinationally; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head reads zero when empty so downstream never sees stale storage.
  assign head_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/result_drain.sv
// Drains the CNN result buffer into a valid/ready stream with last, count and checksum.
// One request per two cycles at best; a full skid FIFO or empty buffer stalls requests.
module result_drain
  import cnn_pkg::*;
#(
  parameter int RESULT_BUFFER_WIDTH = 16,
  parameter int COUNT_WIDTH         = 8,
  parameter int FIFO_DEPTH          = 4,
  parameter int CHECKSUM_WIDTH      = CHECKSUM_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COUNT_WIDTH-1:0]         out_count,
  input  logic [RESULT_BUFFER_WIDTH-1:0] result_buffer_out,
  input  logic                           result_buffer_empty,
  input  logic                           result_buffer_valid,
  output logic                           result_buffer_read_enable,
  output logic [RESULT_BUFFER_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic [CHECKSUM_WIDTH-1:0]      checksum,
  output logic                           spurious_valid
);

  drain_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0]   rem_req_q;
  logic [COUNT_WIDTH-1:0]   rem_out_q;
  logic                     rd_en_q, rd_en_d;
  logic [CHECKSUM_WIDTH-1:0] csum_q;
  logic                     spur_q;
  logic                     fifo_full, fifo_empty;
  logic                     capture, xfer, start_acc, out_drained, can_req;

  assign capture     = rd_en_q && result_buffer_valid;
  assign xfer        = out_valid && out_ready;
  assign start_acc   = start && (state_q == ST_IDLE);
  // True when the stream is finished by the end of this cycle.
  assign out_drained = (rem_out_q == '0) || ((rem_out_q == COUNT_WIDTH'(1)) && xfer);
  assign can_req     = !result_buffer_empty && !fifo_full && (rem_req_q != '0);

  sync_fifo #(
    .WIDTH (RESULT_BUFFER_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (capture),
    .push_dat (result_buffer_out),
    .pop      (xfer),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (out_data)
  );

  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A zero-length drain passes through FLUSH so its done pulse lands
        // two cycles after start, the same offset a finished stream gets.
        if (start) state_d = ST_FLUSH;
        if (start && (out_count != '0)) state_d = ST_REQ;
      end
      ST_REQ: begin
        rd_en_d = can_req && !capture;
        if (capture) state_d = ST_GAP;
      end
      ST_GAP: begin
        // Pre-arm the request so it is already high on the REQ cycle.
        rd_en_d = can_req;
        if (rem_req_q != '0) state_d = ST_REQ;
        else if (out_drained) state_d = ST_DONE;
        else state_d = ST_FLUSH;
      end
      ST_FLUSH: if (out_drained) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rd_en_q   <= 1'b0;
      rem_req_q <= '0;
      rem_out_q <= '0;
      csum_q    <= '0;
      spur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      if (start_acc) begin
        rem_req_q <= out_count;
        rem_out_q <= out_count;
        csum_q    <= '0;
        spur_q    <= 1'b0;
      end else begin
        if (capture && (rem_req_q != '0)) rem_req_q <= rem_req_q - COUNT_WIDTH'(1);
        if (xfer && (rem_out_q != '0))    rem_out_q <= rem_out_q - COUNT_WIDTH'(1);
        if (capture) csum_q <= csum_q + CHECKSUM_WIDTH'(result_buffer_out);
      end
      if (result_buffer_valid && !rd_en_q) spur_q <= 1'b1;
    end
  end

  assign result_buffer_read_enable = rd_en_q;
  assign out_valid      = !fifo_empty;
  assign out_last       = out_valid && (rem_out_q == COUNT_WIDTH'(1));
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign checksum       = csum_q;
  assign spurious_valid = spur_q;

endmodule
